// File: rtl/theta_sweep_ctrl.sv
// theta_sweep_ctrl: commanded sweep sequencer for the SSPWM theta index.
// Steps theta 0..THETA_MAX at a programmable prescaled rate for a programmed
// number of sweeps, with optional dwell at theta=0 between sweeps.
// Optional build macro THETA_UPDOWN_EN selects a triangle sweep
// (0 -> THETA_MAX -> 0) instead of the default sawtooth.
module theta_sweep_ctrl #(
  parameter int unsigned THETA_W   = 7,
  parameter int unsigned THETA_MAX = 88,
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned DWELL_W   = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   div_val,
  input  logic [DWELL_W-1:0] dwell_val,
  input  logic [7:0]         sweeps,
  output logic [THETA_W-1:0] theta,
  output logic               theta_valid,
  output logic               wrap,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = 8;
  localparam logic [THETA_W-1:0] THETA_LAST = THETA_W'(THETA_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state, state_d;

  // Shadow configuration, prescaler and dwell/sweep counters
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   sweeps_q, sweeps_d;
  logic [DIV_W-1:0]   presc, presc_d;
  logic [DWELL_W-1:0] dcnt, dcnt_d;
  logic [CNT_W-1:0]   sweep_cnt, sweep_cnt_d;

  // Next values of the registered outputs
  logic [THETA_W-1:0] theta_d, theta_step;
  logic               theta_valid_d, wrap_d, busy_d, done_d;

  // Decoded conditions
  logic [DIV_W-1:0]   div_m1;
  logic               accept, step, sweep_end, last_sweep, dwell_end;

`ifdef THETA_UPDOWN_EN
  logic dir_down, dir_d, dir_step;
`endif

  // Decode step/sweep/dwell conditions from the current registers
  always_comb begin
    div_m1     = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    accept     = (state == IDLE) && start && !stop;
    step       = (state == RUN) && (presc == div_m1);
`ifdef THETA_UPDOWN_EN
    sweep_end  = step && dir_down && (theta == THETA_W'(1));
`else
    sweep_end  = step && (theta == THETA_LAST);
`endif
    last_sweep = (sweeps_q != '0) && (CNT_W'(sweep_cnt + CNT_W'(1)) == sweeps_q);
    dwell_end  = (dcnt == DWELL_W'(dwell_q - DWELL_W'(1)));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic; stop overrides every other transition
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (accept) state_d = RUN;
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sweep_end) begin
          if (last_sweep)           state_d = DONE;
          else if (dwell_q != '0)   state_d = DWELL;
          else                      state_d = RUN;
        end
      end
      DWELL: begin
        if (stop)           state_d = IDLE;
        else if (dwell_end) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Theta stepping rule (sawtooth or triangle)
  always_comb begin
    theta_step = theta;
`ifdef THETA_UPDOWN_EN
    dir_step = dir_down;
    if (dir_down) begin
      theta_step = theta - THETA_W'(1);
      if (theta == THETA_W'(1)) dir_step = 1'b0;
    end else begin
      theta_step = theta + THETA_W'(1);
      if (THETA_W'(theta + THETA_W'(1)) == THETA_LAST) dir_step = 1'b1;
    end
`else
    theta_step = (theta == THETA_LAST) ? '0 : theta + THETA_W'(1);
`endif
  end

  // Output/datapath next values, derived from current and next state
  always_comb begin
    div_d         = div_q;
    dwell_d       = dwell_q;
    sweeps_d      = sweeps_q;
    sweep_cnt_d   = sweep_cnt;
    presc_d       = '0;
    dcnt_d        = '0;
    theta_d       = '0;
    theta_valid_d = (state_d == RUN);
    busy_d        = (state_d == RUN) || (state_d == DWELL);
    wrap_d        = sweep_end && !stop;
    done_d        = (state == DONE) && !stop;
`ifdef THETA_UPDOWN_EN
    dir_d         = 1'b0;
`endif

    if (accept) begin
      div_d       = div_val;
      dwell_d     = dwell_val;
      sweeps_d    = sweeps;
      sweep_cnt_d = '0;
    end else if (sweep_end && (sweep_cnt != '1)) begin
      sweep_cnt_d = sweep_cnt + CNT_W'(1);
    end

    if (state_d == RUN) begin
      theta_d = step ? theta_step : theta;
`ifdef THETA_UPDOWN_EN
      dir_d   = step ? dir_step : dir_down;
`endif
      if ((state == RUN) && !step) presc_d = presc + DIV_W'(1);
    end

    if ((state == DWELL) && (state_d == DWELL)) dcnt_d = dcnt + DWELL_W'(1);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      dwell_q     <= '0;
      sweeps_q    <= '0;
      presc       <= '0;
      dcnt        <= '0;
      sweep_cnt   <= '0;
      theta       <= '0;
      theta_valid <= 1'b0;
      wrap        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      div_q       <= div_d;
      dwell_q     <= dwell_d;
      sweeps_q    <= sweeps_d;
      presc       <= presc_d;
      dcnt        <= dcnt_d;
      sweep_cnt   <= sweep_cnt_d;
      theta       <= theta_d;
      theta_valid <= theta_valid_d;
      wrap        <= wrap_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

`ifdef THETA_UPDOWN_EN
  // Sweep direction; low means counting up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dir_down <= 1'b0;
    else        dir_down <= dir_d;
  end
`endif

endmodule
